// File: rtl/tcs_emulator.sv
// rtl/tcs_emulator.sv - colour-sensor square-wave emulator; optional scaling via TCS_EMULATOR_SCALE_EN
module tcs_emulator #(
  parameter int SETTLE_CYC = 2,
  parameter int HP_W       = 16
) (
  input  logic            clk_1MHz,
  input  logic            reset,
`ifdef TCS_EMULATOR_SCALE_EN
  input  logic            s0,
  input  logic            s1,
`endif
  input  logic [1:0]      filter,
  input  logic [HP_W-1:0] half_red,
  input  logic [HP_W-1:0] half_green,
  input  logic [HP_W-1:0] half_blue,
  input  logic [HP_W-1:0] half_clear,
  output logic            cs_out,
  output logic            settling
);

`ifdef TCS_EMULATOR_SCALE_EN
  localparam int CW = HP_W + 6;
`else
  localparam int CW = HP_W;
`endif
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN_LO, RUN_HI} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   p_q, p_d;
  logic [1:0]      filt_q;
  logic            armed_q;
  logic            cs_q, cs_d;
  logic [HP_W-1:0] half_sel;
  logic [CW-1:0]   p_new;
  logic            scale_chg;
  logic            power_down;
  logic            change;

  always_comb begin
    case (filt_q)
      2'b00:   half_sel = half_red;
      2'b11:   half_sel = half_green;
      2'b01:   half_sel = half_blue;
      default: half_sel = half_clear;
    endcase
  end

`ifdef TCS_EMULATOR_SCALE_EN
  logic [1:0] scale, scale_q;
  assign scale      = {s0, s1};
  assign scale_chg  = (scale != scale_q);
  assign power_down = (scale == 2'b00);

  always_comb begin
    case (scale)
      2'b10:   p_new = CW'(half_sel) * CW'(5);
      2'b01:   p_new = CW'(half_sel) * CW'(50);
      default: p_new = CW'(half_sel);
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    scale_q <= scale;
  end
`else
  assign p_new      = half_sel;
  assign scale_chg  = 1'b0;
  assign power_down = 1'b0;
`endif

  assign change = (filt_q != filter) || scale_chg;

  // Half-period length is sampled only at a boundary; zero parks in IDLE and polls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    if (power_down) begin
      state_d = IDLE;
      cnt_d   = '0;
      p_d     = '0;
    end else if (change) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!armed_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (p_new != '0) begin
            state_d = RUN_LO;
            p_d     = p_new;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            p_d     = p_new;
            state_d = (p_new == '0) ? IDLE : RUN_LO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN_LO, RUN_HI: begin
          if (cnt_q == p_q - 1'b1) begin
            cnt_d = '0;
            p_d   = p_new;
            if (p_new == '0)
              state_d = IDLE;
            else
              state_d = (state_q == RUN_LO) ? RUN_HI : RUN_LO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    cs_d = (state_d == RUN_HI);
  end

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      filt_q  <= filter;
      armed_q <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      filt_q  <= filter;
      armed_q <= 1'b1;
      cs_q    <= cs_d;
    end
  end

  assign cs_out   = cs_q;
  assign settling = (state_q == SETTLE);

endmodule
